// File: rtl/prm_chk_pkg.sv
// Shared types and constants for the programmable PRM edge checker:
// cube storage format, FSM encoding and the no-hit index.
package prm_chk_pkg;

    localparam int DEF_IN_W  = 15;
    localparam int DEF_TERMS = 256;
    localparam int DEF_CHAN  = 4;
    localparam int DEF_QID_W = 8;

    localparam int ADDR_W = $clog2(DEF_TERMS);
    localparam int NUM_W  = $clog2(DEF_TERMS + 1);

    localparam logic [ADDR_W-1:0] NO_HIT = '1;

    typedef struct packed {
        logic [DEF_IN_W-1:0] care;
        logic [DEF_IN_W-1:0] val;
    } cube_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } state_e;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/prm_term_match.sv
// Combinational CHAN-lane cube matcher: flags any hit among the valid lanes
// and reports the lowest-numbered hitting lane.
module prm_term_match
    import prm_chk_pkg::*;
#(
    parameter int IN_W = DEF_IN_W,
    parameter int CHAN = DEF_CHAN,
    parameter int LW   = (CHAN > 1) ? $clog2(CHAN) : 1
) (
    input  logic [IN_W-1:0]            bits,
    input  logic [CHAN-1:0][IN_W-1:0]  care,
    input  logic [CHAN-1:0][IN_W-1:0]  val,
    input  logic [CHAN-1:0]            lane_vld,
    output logic                       hit,
    output logic [LW-1:0]              lane
);

    logic [CHAN-1:0] match;

    for (genvar j = 0; j < CHAN; j++) begin : g_lane
        assign match[j] = lane_vld[j] && (((bits ^ val[j]) & care[j]) == '0);
    end

    // Descending walk so the lowest hitting lane is the one that sticks.
    always_comb begin
        hit  = |match;
        lane = '0;
        for (int j = CHAN - 1; j >= 0; j--) begin
            if (match[j]) lane = LW'(j);
        end
    end

endmodule

// File: rtl/prm_edge_chk_engine.sv
// Sequential PRM edge checker: scans a loadable cube table CHAN cubes per
// cycle. Build option PRM_CHK_EARLY_EXIT_EN ends the scan on the first hit.
module prm_edge_chk_engine
    import prm_chk_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int TERMS = DEF_TERMS,
    parameter int CHAN  = DEF_CHAN,
    parameter int QID_W = DEF_QID_W
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        cfg_ready,
    input  logic                        cfg_we,
    input  logic [$clog2(TERMS)-1:0]    cfg_addr,
    input  logic [IN_W-1:0]             cfg_care,
    input  logic [IN_W-1:0]             cfg_val,
    input  logic                        cfg_num_we,
    input  logic [$clog2(TERMS+1)-1:0]  cfg_num,
    input  logic                        q_valid,
    output logic                        q_ready,
    input  logic [IN_W-1:0]             q_bits,
    input  logic [QID_W-1:0]            q_id,
    output logic                        r_valid,
    input  logic                        r_ready,
    output logic                        r_mask,
    output logic [QID_W-1:0]            r_id,
    output logic [$clog2(TERMS)-1:0]    r_term
);

    localparam int AW = $clog2(TERMS);
    localparam int NW = $clog2(TERMS + 1);
    localparam int NB = TERMS / CHAN;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int LW = (CHAN > 1) ? $clog2(CHAN) : 1;

    state_e                     state, state_nx;
    cube_t                      mem [TERMS];
    logic [IN_W-1:0]            qb_r;
    logic [QID_W-1:0]           qid_r;
    logic [BW-1:0]              batch;
    logic [BW-1:0]              last_batch;
    logic                       hit_r;
    logic [AW-1:0]              term_r;
    logic [NW-1:0]              num_terms;
    logic                       cfg_ok;
    logic                       scan_end;

    logic [CHAN-1:0][IN_W-1:0]  lane_care, lane_val;
    logic [CHAN-1:0]            lane_vld;
    logic                       m_hit;
    logic [LW-1:0]              m_lane;

    assign cfg_ok = (state == ST_IDLE);

    // Cube table has no reset; entries past num_terms are masked off per lane.
    always_ff @(posedge clk) begin
        if (cfg_we && cfg_ok) mem[cfg_addr] <= '{care: cfg_care, val: cfg_val};
    end

    always_comb begin
        int nb;
        nb = ceil_div(int'(num_terms), CHAN);
        last_batch = (nb == 0) ? '0 : BW'(nb - 1);
    end

    for (genvar j = 0; j < CHAN; j++) begin : g_rd
        logic [AW-1:0] idx;
        assign idx          = AW'(int'(batch) * CHAN + j);
        assign lane_care[j] = mem[idx].care;
        assign lane_val[j]  = mem[idx].val;
        assign lane_vld[j]  = (int'(batch) * CHAN + j) < int'(num_terms);
    end

    prm_term_match #(
        .IN_W (IN_W),
        .CHAN (CHAN),
        .LW   (LW)
    ) u_match (
        .bits     (qb_r),
        .care     (lane_care),
        .val      (lane_val),
        .lane_vld (lane_vld),
        .hit      (m_hit),
        .lane     (m_lane)
    );

`ifdef PRM_CHK_EARLY_EXIT_EN
    assign scan_end = (batch == last_batch) || m_hit;
`else
    assign scan_end = (batch == last_batch);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (q_valid)  state_nx = ST_SCAN;
            ST_SCAN: if (scan_end) state_nx = ST_DONE;
            ST_DONE: if (r_ready)  state_nx = ST_IDLE;
            default:               state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        q_ready   = (state == ST_IDLE);
        cfg_ready = (state == ST_IDLE);
        r_valid   = (state == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qb_r      <= '0;
            qid_r     <= '0;
            batch     <= '0;
            hit_r     <= 1'b0;
            term_r    <= NO_HIT;
            num_terms <= '0;
        end else begin
            if (cfg_num_we && cfg_ok)
                num_terms <= (cfg_num > NW'(TERMS)) ? NW'(TERMS) : cfg_num;
            case (state)
                ST_IDLE: begin
                    if (q_valid) begin
                        qb_r   <= q_bits;
                        qid_r  <= q_id;
                        batch  <= '0;
                        hit_r  <= 1'b0;
                        term_r <= NO_HIT;
                    end
                end
                ST_SCAN: begin
                    batch <= batch + 1'b1;
                    // First hit wins; later batches only hold higher indices.
                    if (m_hit && !hit_r) begin
                        hit_r  <= 1'b1;
                        term_r <= AW'(int'(batch) * CHAN + int'(m_lane));
                    end
                end
                default: ;
            endcase
        end
    end

    assign r_mask = hit_r;
    assign r_id   = qid_r;
    assign r_term = term_r;

endmodule

// File: tb/tb_prm_edge_chk_engine.sv
// Randomized bench for prm_edge_chk_engine against a table-walk reference
// model; honours PRM_CHK_EARLY_EXIT_EN for latency expectations.
module tb_prm_edge_chk_engine;

    localparam int IN_W  = 15;
    localparam int TERMS = 256;
    localparam int CHAN  = 4;
    localparam int QID_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_ready, cfg_we, cfg_num_we;
    logic [7:0]        cfg_addr;
    logic [IN_W-1:0]   cfg_care, cfg_val;
    logic [8:0]        cfg_num;
    logic              q_valid, q_ready;
    logic [IN_W-1:0]   q_bits;
    logic [QID_W-1:0]  q_id;
    logic              r_valid, r_ready, r_mask;
    logic [QID_W-1:0]  r_id;
    logic [7:0]        r_term;

    int checks = 0;
    int failures = 0;

    logic [IN_W-1:0] m_care [TERMS];
    logic [IN_W-1:0] m_val  [TERMS];
    int              m_num = 0;

    always #5 clk = ~clk;

    prm_edge_chk_engine #(
        .IN_W (IN_W), .TERMS (TERMS), .CHAN (CHAN), .QID_W (QID_W)
    ) dut (
        .clk (clk), .rst (rst),
        .cfg_ready (cfg_ready), .cfg_we (cfg_we), .cfg_addr (cfg_addr),
        .cfg_care (cfg_care), .cfg_val (cfg_val),
        .cfg_num_we (cfg_num_we), .cfg_num (cfg_num),
        .q_valid (q_valid), .q_ready (q_ready), .q_bits (q_bits), .q_id (q_id),
        .r_valid (r_valid), .r_ready (r_ready), .r_mask (r_mask),
        .r_id (r_id), .r_term (r_term)
    );

    // Reference: walk the active table, first matching cube wins.
    function automatic void ref_eval(input logic [IN_W-1:0] q, output bit hit, output int term);
        hit  = 1'b0;
        term = 255;
        for (int i = 0; i < m_num && !hit; i++) begin
            if (((q ^ m_val[i]) & m_care[i]) == 0) begin
                hit  = 1'b1;
                term = i;
            end
        end
    endfunction

    function automatic int ref_lat(input bit hit, input int term);
        int nb;
        nb = (m_num + CHAN - 1) / CHAN;
        if (nb < 1) nb = 1;
`ifdef PRM_CHK_EARLY_EXIT_EN
        if (hit) return term / CHAN + 2;
`endif
        return 1 + nb;
    endfunction

    task automatic cube_write(input int a, input logic [IN_W-1:0] c, input logic [IN_W-1:0] v);
        cfg_we = 1'b1; cfg_addr = 8'(a); cfg_care = c; cfg_val = v;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        m_care[a] = c;
        m_val[a]  = v;
    endtask

    task automatic set_num(input int n);
        cfg_num_we = 1'b1; cfg_num = 9'(n);
        @(posedge clk); #1;
        cfg_num_we = 1'b0;
        m_num = (n > TERMS) ? TERMS : n;
    endtask

    // Issues one query and returns once r_valid is seen (or the bound expires).
    task automatic run_query(input logic [IN_W-1:0] b, input logic [QID_W-1:0] id, output int lat);
        q_valid = 1'b1; q_bits = b; q_id = id;
        @(posedge clk); #1;
        q_valid = 1'b0;
        lat = 1;
        while (r_valid !== 1'b1 && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic finish_result();
        r_ready = 1'b1;
        @(posedge clk); #1;
        r_ready = 1'b0;
    endtask

    task automatic test_reset();
        int lat;
        checks++;
        if ({q_ready, cfg_ready, r_valid, r_mask, r_id, r_term} !== {1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'hFF}) begin
            failures++;
            $display("FAIL reset_state: got %b_%b_%b_%b_%h_%h want 1_1_0_0_00_ff",
                     q_ready, cfg_ready, r_valid, r_mask, r_id, r_term);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        run_query(15'h1234, 8'd5, lat);
        checks++;
        if (lat !== 2) begin failures++; $display("FAIL empty_latency: got %0d want 2", lat); end
        checks++;
        if ({r_mask, r_id, r_term} !== {1'b0, 8'd5, 8'hFF}) begin
            failures++;
            $display("FAIL empty_result: got mask=%b id=%h term=%h want 0/05/ff", r_mask, r_id, r_term);
        end
        finish_result();
    endtask

    task automatic test_load_cube();
        logic [IN_W-1:0] qs [2];
        int lat, term;
        bit hit;
        // Background cubes carry 11 in the top bits so they never hit the directed codes.
        for (int i = 0; i < TERMS; i++) cube_write(i, 15'h7FFF, {2'b11, 13'($urandom)});
        cube_write(7, 15'h7FFF, 15'h5AD1);
        set_num(8);
        qs[0] = 15'h5AD1;
        qs[1] = 15'h5AD0;
        for (int k = 0; k < 2; k++) begin
            ref_eval(qs[k], hit, term);
            run_query(qs[k], 8'(k + 16), lat);
            checks++;
            if ({r_mask, r_term} !== {hit, 8'(term)}) begin
                failures++;
                $display("FAIL cube7_q%0d: got mask=%b term=%0d want %b/%0d", k, r_mask, r_term, hit, term);
            end
            checks++;
            if (lat !== ref_lat(hit, term)) begin
                failures++;
                $display("FAIL cube7_lat%0d: got %0d want %0d", k, lat, ref_lat(hit, term));
            end
            finish_result();
        end
    endtask

    task automatic test_first_hit();
        int lat, term;
        bit hit;
        cube_write(3, 15'h0003, 15'h0001);
        cube_write(200, 15'h0003, 15'h0001);
        set_num(256);
        ref_eval(15'h0F01, hit, term);
        run_query(15'h0F01, 8'h33, lat);
        checks++;
        if ({r_mask, r_term, r_id} !== {1'b1, 8'd3, 8'h33} || term != 3) begin
            failures++;
            $display("FAIL first_hit: got mask=%b term=%0d id=%h want 1/3/33", r_mask, r_term, r_id);
        end
        checks++;
        if (lat !== ref_lat(hit, term)) begin
            failures++;
            $display("FAIL first_hit_lat: got %0d want %0d", lat, ref_lat(hit, term));
        end
        finish_result();
    endtask

    task automatic test_stall();
        int lat, term;
        bit hit;
        logic [QID_W+8:0] cap;
        set_num(8);
        run_query(15'h5AD1, 8'h77, lat);
        cap = {r_mask, r_id, r_term};
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin cfg_we = 1'b1; cfg_addr = 8'd0; cfg_care = '0; cfg_val = '0; end
            @(posedge clk); #1;
            cfg_we = 1'b0;
            checks++;
            if ({r_valid, q_ready, cfg_ready, r_mask, r_id, r_term} !== {3'b100, cap}) begin
                failures++;
                $display("FAIL stall_hold%0d: got v=%b qr=%b cr=%b out=%h want 1/0/0/%h",
                         i, r_valid, q_ready, cfg_ready, {r_mask, r_id, r_term}, cap);
            end
        end
        finish_result();
        // A landed write (care=0 at cube 0) would make this code hit index 0.
        ref_eval(15'h0000, hit, term);
        run_query(15'h0000, 8'h01, lat);
        checks++;
        if ({r_mask, r_term} !== {hit, 8'(term)}) begin
            failures++;
            $display("FAIL stall_write_ignored: got mask=%b term=%0d want %b/%0d", r_mask, r_term, hit, term);
        end
        finish_result();
    endtask

    task automatic test_back_to_back();
        int lat, term, n, idx;
        bit hit;
        logic [IN_W-1:0] b;
        logic [QID_W-1:0] id;
        for (int it = 0; it < 24; it++) begin
            if (it % 6 == 0) begin
                n = (it == 0) ? 256 : int'($urandom_range(0, 256));
                set_num(n);
            end
            if ($urandom_range(0, 3) == 0)
                cube_write(int'($urandom_range(0, 255)), 15'($urandom & $urandom), 15'($urandom));
            if (m_num > 0 && $urandom_range(0, 2) != 0) begin
                idx = int'($urandom_range(0, m_num - 1));
                b = m_val[idx];
                if ($urandom_range(0, 1) == 1) b = b ^ 15'(1 << $urandom_range(0, 14));
            end else begin
                b = 15'($urandom);
            end
            id = 8'($urandom);
            checks++;
            if (q_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready%0d: got %b want 1", it, q_ready); end
            ref_eval(b, hit, term);
            run_query(b, id, lat);
            checks++;
            if ({r_mask, r_term, r_id} !== {hit, 8'(term), id}) begin
                failures++;
                $display("FAIL rand%0d q=%h n=%0d: got mask=%b term=%0d id=%h want %b/%0d/%h",
                         it, b, m_num, r_mask, r_term, r_id, hit, term, id);
            end
            checks++;
            if (lat !== ref_lat(hit, term)) begin
                failures++;
                $display("FAIL rand_lat%0d: got %0d want %0d", it, lat, ref_lat(hit, term));
            end
            finish_result();
        end
    endtask

    task automatic test_reset_mid_scan();
        int lat;
        set_num(256);
        cube_write(250, 15'h7FFF, 15'h2ABC);
        q_valid = 1'b1; q_bits = 15'h2ABC; q_id = 8'h42;
        @(posedge clk); #1;
        q_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({r_valid, q_ready, cfg_ready} !== 3'b011) begin
            failures++;
            $display("FAIL mid_scan_reset: got v=%b qr=%b cr=%b want 0/1/1", r_valid, q_ready, cfg_ready);
        end
        #2 rst = 1'b0;
        m_num = 0;
        @(posedge clk); #1;
        checks++;
        if ({r_valid, q_ready} !== 2'b01) begin
            failures++;
            $display("FAIL after_reset_idle: got v=%b qr=%b want 0/1", r_valid, q_ready);
        end
        run_query(15'h2ABC, 8'h43, lat);
        checks++;
        if ({r_mask, r_term, lat} !== {1'b0, 8'hFF, 32'd2}) begin
            failures++;
            $display("FAIL requery_after_reset: got mask=%b term=%h lat=%0d want 0/ff/2", r_mask, r_term, lat);
        end
        finish_result();
    endtask

    task automatic test_saturate();
        int lat, term;
        bit hit;
        logic [IN_W-1:0] b;
        set_num(300);
        cube_write(255, 15'h0000, 15'h1234);
        for (int k = 0; k < 3; k++) begin
            b = {2'b00, 11'($urandom), 2'b10};
            ref_eval(b, hit, term);
            run_query(b, 8'(k), lat);
            checks++;
            if ({r_mask, r_term} !== {hit, 8'(term)} || !hit) begin
                failures++;
                $display("FAIL saturate%0d q=%h: got mask=%b term=%0d want %b/%0d", k, b, r_mask, r_term, hit, term);
            end
            checks++;
            if (lat !== ref_lat(hit, term)) begin
                failures++;
                $display("FAIL saturate_lat%0d: got %0d want %0d", k, lat, ref_lat(hit, term));
            end
            finish_result();
        end
    endtask

    initial begin
        cfg_we = 1'b0; cfg_num_we = 1'b0; cfg_addr = '0; cfg_care = '0; cfg_val = '0; cfg_num = '0;
        q_valid = 1'b0; q_bits = '0; q_id = '0; r_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_load_cube();
        test_first_hit();
        test_stall();
        test_back_to_back();
        test_reset_mid_scan();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/prm_edge_chk_engine.md
# prm_edge_chk_engine

Programmable, sequential successor to the hard-wired PRM obstacle-logic checkers. Instead of one fixed sum-of-products per obstacle, it holds a loadable table of up to TERMS cubes (care mask + value over IN_W joint-space bits). It scans that table CHAN cubes per cycle against queued edge queries and returns edge_mask plus the index of the first matching cube. It sits between the roadmap edge generator and the edge-pruning stage. It replaces one combinational checker per obstacle with one reloadable engine.

## Interface
- IN_W, 15, query/cube bit width
- TERMS, 256, cube table depth
- CHAN, 4, cubes evaluated per cycle (must divide TERMS)
- QID_W, 8, query tag width
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cfg_ready  out  1  table writable (engine IDLE)
- cfg_we  in  1  write cube at cfg_addr
- cfg_addr  in  $clog2(TERMS)  cube index
- cfg_care  in  IN_W  care mask (1 = bit significant)
- cfg_val  in  IN_W  required value on cared bits
- cfg_num_we  in  1  load cfg_num into term count
- cfg_num  in  $clog2(TERMS+1)  number of active cubes, 0..TERMS
- q_valid / q_ready  in / out  1  query handshake
- q_bits  in  IN_W  joint-space code (bit 0 = A … bit 14 = O)
- q_id  in  QID_W  query tag
- r_valid / r_ready  out / in  1  result handshake
- r_mask  out  1  1 = edge collides (any active cube matched)
- r_id  out  QID_W  echoed tag
- r_term  out  $clog2(TERMS)  lowest matching cube index; all-ones if none

## Operation
- Cube i matches when ((q_bits ^ val[i]) & care[i]) == 0, for i < num_terms. A cube with care = 0 matches everything.
- FSM states are IDLE, SCAN and DONE.
  - IDLE: q_ready = 1, cfg_ready = 1. On q_valid, latch q_bits and q_id, set batch = 0, clear hit, go to SCAN.
  - SCAN: each cycle, evaluate cubes batch*CHAN … batch*CHAN+CHAN-1. Lanes at or beyond num_terms are forced to no-match. On the first hit, record the lowest matching index; later hits never overwrite it. Go to DONE after the last batch, ceil(num_terms/CHAN)-1, or after batch 0 when num_terms = 0.
  - DONE: r_valid = 1 with stable outputs until r_ready, then go to IDLE.
- Config:
  - cfg_we and cfg_num_we take effect only while cfg_ready = 1; they are silently ignored otherwise.
  - If cfg_we and a query accept occur in the same cycle, the write lands first and the query sees the new cube.
  - cfg_num > TERMS saturates to TERMS.
- Reset:
  - q_ready = 1, cfg_ready = 1, r_valid = 0, r_mask = 0, r_id = 0, r_term = all-ones, num_terms = 0, state IDLE.
  - Cube storage is not reset. It is irrelevant while num_terms = 0.
  - Reset mid-SCAN or mid-DONE drops the query with no result emitted.

## Timing
- A query is accepted in cycle t. Batch k is evaluated in cycle t+1+k.
- r_valid rises in cycle t+1+max(1, ceil(num_terms/CHAN)).
- Full-scan latency at defaults is 64 cycles in SCAN plus 1.
- r_valid stalls indefinitely under r_ready = 0; outputs hold.
- Throughput is one query per (scan + 2) cycles. There is no overlap: q_ready = 0 from accept until the result handshake completes.
- The r_ready handshake cycle returns to IDLE. The next query can be accepted in the following cycle.

## Configuration
- PRM_CHK_EARLY_EXIT_EN
  - Defined: SCAN leaves to DONE in the cycle the first hit is recorded. Latency on a hit in batch k is k+2 cycles.
  - Undefined: all batches are always scanned, giving constant latency for a fixed num_terms.
  - r_mask and r_term are identical in both builds.

## Structure
- Package prm_chk_pkg holds:
  - cube struct {care, val}
  - FSM state enum
  - NO_HIT constant (all-ones index)
  - width localparams derived from IN_W/TERMS
- Sub-module prm_term_match: combinational CHAN-lane matcher. It takes the query, CHAN cubes and a lane-valid vector, and outputs hit and the lowest hitting lane.

## Test plan
- Reset, num_terms = 0, query 0x1234 id 5 → r_valid at t+2, r_mask = 0, r_id = 5, r_term = 0xFF.
- Load cube 7 with care = 0x7FFF, val = 0x5AD1, and set num_terms = 8. Query 0x5AD1 → r_mask = 1, r_term = 7. Query 0x5AD0 → r_mask = 0.
- Cubes 3 and 200 both with care = 0x0003, val = 0x0001, num_terms = 256. Query 0x0F01 → r_term = 3. Latency is 65 cycles without PRM_CHK_EARLY_EXIT_EN and 2 cycles with it.
- Hold r_ready low 10 cycles in DONE → outputs stable, q_ready = 0. During the stall, cfg_we on cube 0 → ignored; a later read-back query proves the cube is unchanged.
- Assert rst mid-SCAN → no r_valid; state IDLE next cycle. num_terms resets to 0, so a re-query of a previously matching code returns r_mask = 0.
- Set cfg_num = 300 → saturates to 256. A cube at index 255 with care = 0 matches any query; r_term = 255 when no lower cube hits.
